// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
// Imported by the emulator top and its bounce LFSR.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BOUNCE,
    HELD,
    RELEASE_BOUNCE
  } emu_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0]  ROW_IDLE  = 4'hF;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic      on;
    key_code_t key;
  } row_req_t;

  function automatic logic [3:0] row_drive(
    input row_req_t   req,
    input logic [3:0] col
  );
    logic [3:0] rows;
    rows = ROW_IDLE;
    if (req.on && !col[req.key[1:0]]) begin
      rows[req.key[3:2]] = 1'b0;
    end
    return rows;
  endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// Free-running 16-bit Galois LFSR that paces contact bounce.
// Only the low bit is consumed by the emulator.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  output logic bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 column-drive / row-sense keypad scan,
// emulating one key with press and release contact bounce.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYCLES  = 1000,
  parameter int          BOUNCE_MIN_GAP = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keypad_column,
  output logic [3:0]  keypad_row,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] hold_cycles,
  output logic        key_ready,
  output logic        contact,
  output logic        release_done
);

  localparam int BW =
    (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
  localparam int GW =
    (BOUNCE_MIN_GAP > 1) ? $clog2(BOUNCE_MIN_GAP) : 1;
  localparam logic [BW-1:0] B_LAST =
    BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [GW-1:0] G_SAT =
    GW'(BOUNCE_MIN_GAP - 1);

  emu_state_t  state_q, state_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;
  key_code_t   key_q, key_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [3:0]  sync1_q, sync2_q;
  row_req_t    pipe1_q, pipe2_q;
  logic [3:0]  row_q;

  logic        lfsr_bit;
  logic        tog;
  logic [15:0] hold_last;

  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .bit_o (lfsr_bit)
  );

  assign tog = lfsr_bit && (gap_q >= G_SAT);
  // A zero hold still keeps the key solidly closed for one cycle.
  assign hold_last = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    key_d     = key_q;
    hold_d    = hold_q;
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    gap_d     = gap_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = PRESS_BOUNCE;
          key_d   = key_code;
          hold_d  = hold_cycles;
          bcnt_d  = '0;
          gap_d   = '0;
        end
      end
      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (bcnt_q == B_LAST) begin
          if (state_q == PRESS_BOUNCE) begin
            contact_d = 1'b1;
            state_d   = HELD;
            hcnt_d    = '0;
          end else begin
            contact_d = 1'b0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
          if (tog) begin
            contact_d = ~contact_q;
            gap_d     = '0;
          end else if (gap_q < G_SAT) begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      HELD: begin
        if (hcnt_q == hold_last) begin
          state_d = RELEASE_BOUNCE;
          bcnt_d  = '0;
          gap_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      key_q     <= '0;
      hold_q    <= '0;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      hcnt_q    <= hcnt_d;
      bcnt_q    <= bcnt_d;
      gap_q     <= gap_d;
    end
  end

  // Contact and key ride two stages so they line up with the column sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= ROW_IDLE;
      sync2_q <= ROW_IDLE;
      pipe1_q <= '0;
      pipe2_q <= '0;
      row_q   <= ROW_IDLE;
    end else begin
      sync1_q <= keypad_column;
      sync2_q <= sync1_q;
      pipe1_q <= '{on: contact_q, key: key_q};
      pipe2_q <= pipe1_q;
      row_q   <= row_drive(pipe2_q, sync2_q);
    end
  end

  assign keypad_row   = row_q;
  assign contact      = contact_q;
  assign key_ready    = (state_q == IDLE);
  assign release_done = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: three bounce configurations
// checked each cycle against a reference model and row scoreboard.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col;
  logic        kv;
  logic [3:0]  kc;
  logic [15:0] hc;

  logic [3:0] row_a, row_b, row_c;
  logic rdy_a, rdy_b, rdy_c;
  logic con_a, con_b, con_c;
  logic rel_a, rel_b, rel_c;
  logic [2:0] rdyv, conv, relv;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign rdyv = {rdy_c, rdy_b, rdy_a};
  assign conv = {con_c, con_b, con_a};
  assign relv = {rel_c, rel_b, rel_a};

  keypad_emulator #(
    .BOUNCE_CYCLES(8), .BOUNCE_MIN_GAP(2), .LFSR_SEED(16'hACE1)
  ) u_a (
    .clk(clk), .reset(reset), .keypad_column(col),
    .keypad_row(row_a), .key_valid(kv), .key_code(kc),
    .hold_cycles(hc), .key_ready(rdy_a), .contact(con_a),
    .release_done(rel_a)
  );

  keypad_emulator #(
    .BOUNCE_CYCLES(64), .BOUNCE_MIN_GAP(4), .LFSR_SEED(16'hACE1)
  ) u_b (
    .clk(clk), .reset(reset), .keypad_column(col),
    .keypad_row(row_b), .key_valid(kv), .key_code(kc),
    .hold_cycles(hc), .key_ready(rdy_b), .contact(con_b),
    .release_done(rel_b)
  );

  keypad_emulator #(
    .BOUNCE_CYCLES(0), .BOUNCE_MIN_GAP(1), .LFSR_SEED(16'hACE1)
  ) u_c (
    .clk(clk), .reset(reset), .keypad_column(col),
    .keypad_row(row_c), .key_valid(kv), .key_code(kc),
    .hold_cycles(hc), .key_ready(rdy_c), .contact(con_c),
    .release_done(rel_c)
  );

  typedef struct packed {
    int         st;
    logic       con;
    logic       rel;
    logic [3:0] key;
    int         hold;
    int         bc;
    int         gap;
    int         hc;
  } mdl_t;

  mdl_t        m [3];
  logic [15:0] ml;
  logic [11:0] rq[$];

  function automatic int bcy(input int i);
    case (i)
      0: return 8;
      1: return 64;
      default: return 0;
    endcase
  endfunction

  function automatic int mgp(input int i);
    case (i)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] lnext(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference model; states 0..3 = idle, press, held, release.
  function automatic mdl_t step(
    input mdl_t s, input int bw, input int mg, input logic l0,
    input logic v, input logic [3:0] code, input logic [15:0] hold
  );
    mdl_t n;
    n = s;
    n.rel = 1'b0;
    case (s.st)
      0: if (v) begin
        n.st = 1; n.key = code; n.bc = 0; n.gap = 0;
        n.hold = (hold == 16'd0) ? 1 : int'(hold);
      end
      1, 3: begin
        if (bw == 0 || s.bc >= bw - 1) begin
          n.con = (s.st == 1);
          n.rel = (s.st == 3);
          n.st  = (s.st == 1) ? 2 : 0;
          n.hc  = 0;
        end else begin
          n.bc = s.bc + 1;
          if (s.gap >= mg - 1 && l0) begin
            n.con = ~s.con; n.gap = 0;
          end else begin
            n.gap = s.gap + 1;
          end
        end
      end
      2: if (s.hc >= s.hold - 1) begin
        n.st = 3; n.bc = 0; n.gap = 0;
      end else begin
        n.hc = s.hc + 1;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
      ml <= 16'hACE1;
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= step(m[i], bcy(i), mgp(i), ml[0], kv, kc, hc);
      ml <= lnext(ml);
    end
  end

  function automatic logic [3:0] exp_row(
    input logic c, input logic [3:0] k, input logic [3:0] cl
  );
    logic [3:0] r;
    r = 4'hF;
    if (c && cl[k[1:0]] == 1'b0) r[k[3:2]] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] rowv(input int i);
    case (i)
      0: return row_a;
      1: return row_b;
      default: return row_c;
    endcase
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] got, input logic [31:0] exp
  );
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic [11:0] e;
    if (reset)
      rq.push_back({exp_row(m[2].con, m[2].key, col),
                    exp_row(m[1].con, m[1].key, col),
                    exp_row(m[0].con, m[0].key, col)});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("con%0d", i), 32'(conv[i]), 32'(m[i].con));
      chk($sformatf("rdy%0d", i), 32'(rdyv[i]), 32'(m[i].st == 0));
      chk($sformatf("rel%0d", i), 32'(relv[i]), 32'(m[i].rel));
    end
    if (reset) begin
      if (rq.size() == 0) begin
        chk("rq_size", 32'(rq.size()), 32'd1);
      end else begin
        e = rq.pop_front();
        for (int i = 0; i < 3; i++)
          chk($sformatf("row%0d", i), 32'(rowv(i)), 32'(e[4*i +: 4]));
      end
    end else begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("rst_row%0d", i), 32'(rowv(i)), 32'hF);
    end
  endtask

  task automatic release_reset();
    reset = 1'b1;
    rq.delete();
    rq.push_back(12'hFFF);
    rq.push_back(12'hFFF);
  endtask

  function automatic logic [3:0] rot(input int i);
    case (i)
      0: return 4'hE;
      1: return 4'hD;
      2: return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  initial begin
    int lt, nt1, nt2, ra;
    int ta, tb, tc, na, nb, nc;
    logic pb;

    reset = 1'b0; col = 4'h0; kv = 1'b0; kc = 4'h0; hc = 16'd0;
    repeat (5) tick();
    chk("rst_row_a", 32'(row_a), 32'hF);
    chk("rst_rdy_a", 32'(rdy_a), 32'd1);
    chk("rst_con_a", 32'(con_a), 32'd0);
    chk("rst_rel_a", 32'(rel_a), 32'd0);

    release_reset();
    tick();
    chk("lfsr_first", 32'(u_a.u_lfsr.lfsr_q), 32'hE270);

    // Steady press, column scan, busy rejection.
    kv = 1'b1; kc = 4'b0110; hc = 16'd20; col = 4'b1011;
    tick();
    kv = 1'b0;
    chk("acc_busy_a", 32'(rdy_a), 32'd0);
    ra = 0; lt = -100; nt1 = 0; nt2 = 0; pb = con_b;
    for (int k = 1; k <= 150; k++) begin
      int s;
      s = k - 1;
      if (k == 1 || k == 85) lt = -100;
      col = (s >= 8 && s <= 23) ? rot((s - 8) / 4) : 4'b1011;
      kv = (s == 13);
      kc = (s == 13) ? 4'h3 : 4'h6;
      hc = (s == 13) ? 16'd5 : 16'd20;
      if (s == 13) begin
        chk("busy_rdy_a", 32'(rdy_a), 32'd0);
        chk("busy_rdy_b", 32'(rdy_b), 32'd0);
      end
      tick();
      if (rel_a) ra++;
      if (k == 20) chk("scan_hit", 32'(row_a), 32'hD);
      if (k == 24) chk("scan_miss", 32'(row_a), 32'hF);
      if (k == 27) chk("key_kept", 32'(row_a), 32'hD);
      if (k == 22) chk("rel_c_22", 32'(rel_c), 32'd1);
      if (k == 35 || k == 37) chk("rel_a_edge", 32'(rel_a), 32'd0);
      if (k == 36) chk("rel_a_36", 32'(rel_a), 32'd1);
      if (k == 39) chk("row_a_off", 32'(row_a), 32'hF);
      if (k == 64) chk("b_press_end", 32'(con_b), 32'd1);
      if (k == 148) begin
        chk("b_rel_end", 32'(con_b), 32'd0);
        chk("rel_b_148", 32'(rel_b), 32'd1);
      end
      if (con_b !== pb &&
          ((k >= 1 && k <= 63) || (k >= 85 && k <= 147))) begin
        chk("b_gap", 32'(k - lt >= 4), 32'd1);
        lt = k;
        if (k < 64) nt1++; else nt2++;
      end
      pb = con_b;
    end
    kv = 1'b0;
    chk("rel_a_once", 32'(ra), 32'd1);
    chk("b_tog_press", 32'(nt1 >= 1), 32'd1);
    chk("b_tog_rel", 32'(nt2 >= 1), 32'd1);

    // Reset while the key is held closed.
    kv = 1'b1; kc = 4'b1101; hc = 16'd40; col = 4'b1101;
    tick();
    kv = 1'b0;
    repeat (20) tick();
    chk("pre_rst_row", 32'(row_a), 32'h7);
    reset = 1'b0;
    #1;
    chk("mid_rst_row_a", 32'(row_a), 32'hF);
    chk("mid_rst_row_b", 32'(row_b), 32'hF);
    chk("mid_rst_con_a", 32'(con_a), 32'd0);
    chk("mid_rst_rel_a", 32'(rel_a), 32'd0);
    chk("mid_rst_rdy_a", 32'(rdy_a), 32'd1);
    rq.delete();
    repeat (2) tick();
    release_reset();

    kv = 1'b1; kc = 4'b0000; hc = 16'd3; col = 4'b1110;
    tick();
    kv = 1'b0;
    ta = -1; tb = -1; tc = -1; na = 0; nb = 0; nc = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 11) chk("post_row_a", 32'(row_a), 32'hE);
      if (rel_a) begin na++; if (ta < 0) ta = k; end
      if (rel_b) begin nb++; if (tb < 0) tb = k; end
      if (rel_c) begin nc++; if (tc < 0) tc = k; end
    end
    chk("post_rel_a", 32'(ta), 32'd19);
    chk("post_rel_b", 32'(tb), 32'd131);
    chk("post_rel_c", 32'(tc), 32'd5);
    chk("post_cnt_a", 32'(na), 32'd1);
    chk("post_cnt_b", 32'(nb), 32'd1);
    chk("post_cnt_c", 32'(nc), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
